// File: rtl/mem_access_arbiter.sv
// Arbitrates the main-memory request port between I-cache fills and the D-cache
// port, allocating read/write serials and routing responses back by serial owner.
module mem_access_arbiter #(
  parameter  int ADDR_W   = 32,
  parameter  int LINE_W   = 64,
  parameter  int RSER_NUM = 3,
  parameter  int WSER_NUM = 2,
  localparam int RS_W     = $clog2(RSER_NUM),
  localparam int WS_W     = $clog2(WSER_NUM),
  localparam int IF_W     = $clog2(RSER_NUM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ack,
  output logic [RS_W-1:0]   ic_req_serial,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  output logic              dc_req_ack,
  output logic [RS_W-1:0]   dc_req_serial,
  output logic [WS_W-1:0]   dc_req_wserial,
  output logic              mem_req_valid,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_data,
  output logic [RS_W-1:0]   mem_req_serial,
  output logic [WS_W-1:0]   mem_req_wserial,
  input  logic              mem_req_ready,
  input  logic              mem_rd_valid,
  input  logic [RS_W-1:0]   mem_rd_serial,
  input  logic [LINE_W-1:0] mem_rd_data,
  input  logic              mem_wr_valid,
  input  logic [WS_W-1:0]   mem_wr_serial,
  output logic              ic_rd_valid,
  output logic              dc_rd_valid,
  output logic [RS_W-1:0]   rd_serial,
  output logic [LINE_W-1:0] rd_data,
  output logic              dc_wr_valid,
  output logic [WS_W-1:0]   dc_wr_serial,
  output logic [IF_W-1:0]   rd_inflight,
  output logic              err
);

  logic [RSER_NUM-1:0] rfree_q, rfree_d, rowner_q, rowner_d;
  logic [WSER_NUM-1:0] wfree_q, wfree_d;
  logic                last_dc_q, last_dc_d;

  logic                slot_valid_q, slot_valid_d;
  logic                slot_we_q, slot_we_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic [LINE_W-1:0]   slot_data_q, slot_data_d;
  logic [RS_W-1:0]     slot_ser_q, slot_ser_d;
  logic [WS_W-1:0]     slot_wser_q, slot_wser_d;

  logic                ic_rd_valid_q, ic_rd_valid_d;
  logic                dc_rd_valid_q, dc_rd_valid_d;
  logic [RS_W-1:0]     rd_serial_q, rd_serial_d;
  logic [LINE_W-1:0]   rd_data_q, rd_data_d;
  logic                dc_wr_valid_q, dc_wr_valid_d;
  logic [WS_W-1:0]     dc_wr_serial_q, dc_wr_serial_d;
  logic                err_q, err_d;

  logic [RS_W-1:0]     ridx;
  logic [WS_W-1:0]     widx;
  logic                rd_hit_free, rd_owner, wr_hit_free;
  logic [IF_W-1:0]     inflight;

  always_comb begin
    ridx        = '0;
    widx        = '0;
    rd_hit_free = 1'b1;
    rd_owner    = 1'b0;
    wr_hit_free = 1'b1;
    inflight    = IF_W'(RSER_NUM);
    for (int i = RSER_NUM - 1; i >= 0; i--) begin
      if (rfree_q[i]) ridx = RS_W'(i);
    end
    for (int i = WSER_NUM - 1; i >= 0; i--) begin
      if (wfree_q[i]) widx = WS_W'(i);
    end
    // Serials outside the pool look free, so they are reported as errors.
    for (int i = 0; i < RSER_NUM; i++) begin
      if (mem_rd_serial == RS_W'(i)) begin
        rd_hit_free = rfree_q[i];
        rd_owner    = rowner_q[i];
      end
      if (rfree_q[i]) inflight = inflight - IF_W'(1);
    end
    for (int i = 0; i < WSER_NUM; i++) begin
      if (mem_wr_serial == WS_W'(i)) wr_hit_free = wfree_q[i];
    end
  end

  logic slot_ok, ic_elig, dc_elig, grant_ic, grant_dc, grant_rd, rd_ok, wr_ok;

  assign slot_ok  = !slot_valid_q || mem_req_ready;
  assign ic_elig  = ic_req_valid && (|rfree_q);
  assign dc_elig  = dc_req_valid && (dc_req_we ? (|wfree_q) : (|rfree_q));
  assign grant_ic = slot_ok && ic_elig && (!dc_elig || last_dc_q);
  assign grant_dc = slot_ok && dc_elig && !grant_ic;
  assign grant_rd = grant_ic || (grant_dc && !dc_req_we);
  assign rd_ok    = mem_rd_valid && !rd_hit_free;
  assign wr_ok    = mem_wr_valid && !wr_hit_free;

  always_comb begin
    rfree_d        = rfree_q;
    rowner_d       = rowner_q;
    wfree_d        = wfree_q;
    last_dc_d      = last_dc_q;
    slot_valid_d   = slot_valid_q;
    slot_we_d      = slot_we_q;
    slot_addr_d    = slot_addr_q;
    slot_data_d    = slot_data_q;
    slot_ser_d     = slot_ser_q;
    slot_wser_d    = slot_wser_q;
    rd_serial_d    = rd_serial_q;
    rd_data_d      = rd_data_q;
    dc_wr_serial_d = dc_wr_serial_q;
    ic_rd_valid_d  = rd_ok && !rd_owner;
    dc_rd_valid_d  = rd_ok && rd_owner;
    dc_wr_valid_d  = wr_ok;
    err_d          = err_q || (mem_rd_valid && !rd_ok) || (mem_wr_valid && !wr_ok);

    // Allocation uses the pre-free bitmap, so it never collides with a freed index.
    for (int i = 0; i < RSER_NUM; i++) begin
      if (grant_rd && ridx == RS_W'(i)) begin
        rfree_d[i]  = 1'b0;
        rowner_d[i] = grant_dc;
      end
      if (rd_ok && mem_rd_serial == RS_W'(i)) rfree_d[i] = 1'b1;
    end
    for (int i = 0; i < WSER_NUM; i++) begin
      if (grant_dc && dc_req_we && widx == WS_W'(i)) wfree_d[i] = 1'b0;
      if (wr_ok && mem_wr_serial == WS_W'(i)) wfree_d[i] = 1'b1;
    end

    if (grant_ic || grant_dc) begin
      last_dc_d    = grant_dc;
      slot_valid_d = 1'b1;
      slot_we_d    = grant_dc && dc_req_we;
      slot_addr_d  = grant_dc ? dc_req_addr : ic_req_addr;
      slot_data_d  = (grant_dc && dc_req_we) ? dc_req_data : '0;
      slot_ser_d   = grant_rd ? ridx : '0;
      slot_wser_d  = (grant_dc && dc_req_we) ? widx : '0;
    end else if (mem_req_ready) begin
      slot_valid_d = 1'b0;
    end

    if (rd_ok) begin
      rd_serial_d = mem_rd_serial;
      rd_data_d   = mem_rd_data;
    end
    if (wr_ok) dc_wr_serial_d = mem_wr_serial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfree_q        <= '1;
      rowner_q       <= '0;
      wfree_q        <= '1;
      last_dc_q      <= 1'b1;
      slot_valid_q   <= 1'b0;
      slot_we_q      <= 1'b0;
      slot_addr_q    <= '0;
      slot_data_q    <= '0;
      slot_ser_q     <= '0;
      slot_wser_q    <= '0;
      ic_rd_valid_q  <= 1'b0;
      dc_rd_valid_q  <= 1'b0;
      rd_serial_q    <= '0;
      rd_data_q      <= '0;
      dc_wr_valid_q  <= 1'b0;
      dc_wr_serial_q <= '0;
      err_q          <= 1'b0;
    end else begin
      rfree_q        <= rfree_d;
      rowner_q       <= rowner_d;
      wfree_q        <= wfree_d;
      last_dc_q      <= last_dc_d;
      slot_valid_q   <= slot_valid_d;
      slot_we_q      <= slot_we_d;
      slot_addr_q    <= slot_addr_d;
      slot_data_q    <= slot_data_d;
      slot_ser_q     <= slot_ser_d;
      slot_wser_q    <= slot_wser_d;
      ic_rd_valid_q  <= ic_rd_valid_d;
      dc_rd_valid_q  <= dc_rd_valid_d;
      rd_serial_q    <= rd_serial_d;
      rd_data_q      <= rd_data_d;
      dc_wr_valid_q  <= dc_wr_valid_d;
      dc_wr_serial_q <= dc_wr_serial_d;
      err_q          <= err_d;
    end
  end

  assign ic_req_ack      = grant_ic;
  assign ic_req_serial   = grant_ic ? ridx : '0;
  assign dc_req_ack      = grant_dc;
  assign dc_req_serial   = (grant_dc && !dc_req_we) ? ridx : '0;
  assign dc_req_wserial  = (grant_dc && dc_req_we) ? widx : '0;
  assign mem_req_valid   = slot_valid_q;
  assign mem_req_we      = slot_we_q;
  assign mem_req_addr    = slot_addr_q;
  assign mem_req_data    = slot_data_q;
  assign mem_req_serial  = slot_ser_q;
  assign mem_req_wserial = slot_wser_q;
  assign ic_rd_valid     = ic_rd_valid_q;
  assign dc_rd_valid     = dc_rd_valid_q;
  assign rd_serial       = rd_serial_q;
  assign rd_data         = rd_data_q;
  assign dc_wr_valid     = dc_wr_valid_q;
  assign dc_wr_serial    = dc_wr_serial_q;
  assign rd_inflight     = inflight;
  assign err             = err_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: stimulus pushes expected acks, memory
// requests and routed responses into queues; a monitor pops and compares them.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req_valid = 0;
  logic [31:0] ic_req_addr = 0;
  logic        ic_req_ack;
  logic [1:0]  ic_req_serial;
  logic        dc_req_valid = 0, dc_req_we = 0;
  logic [31:0] dc_req_addr = 0;
  logic [63:0] dc_req_data = 0;
  logic        dc_req_ack;
  logic [1:0]  dc_req_serial;
  logic [0:0]  dc_req_wserial;
  logic        mem_req_valid, mem_req_we;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic [1:0]  mem_req_serial;
  logic [0:0]  mem_req_wserial;
  logic        mem_req_ready = 0;
  logic        mem_rd_valid = 0;
  logic [1:0]  mem_rd_serial = 0;
  logic [63:0] mem_rd_data = 0;
  logic        mem_wr_valid = 0;
  logic [0:0]  mem_wr_serial = 0;
  logic        ic_rd_valid, dc_rd_valid;
  logic [1:0]  rd_serial;
  logic [63:0] rd_data;
  logic        dc_wr_valid;
  logic [0:0]  dc_wr_serial;
  logic [1:0]  rd_inflight;
  logic        err;

  mem_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_req_ack(ic_req_ack), .ic_req_serial(ic_req_serial),
    .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_ack(dc_req_ack), .dc_req_serial(dc_req_serial),
    .dc_req_wserial(dc_req_wserial),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_serial(mem_req_serial),
    .mem_req_wserial(mem_req_wserial), .mem_req_ready(mem_req_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_serial(mem_rd_serial), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_serial(mem_wr_serial),
    .ic_rd_valid(ic_rd_valid), .dc_rd_valid(dc_rd_valid), .rd_serial(rd_serial),
    .rd_data(rd_data), .dc_wr_valid(dc_wr_valid), .dc_wr_serial(dc_wr_serial),
    .rd_inflight(rd_inflight), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // {is_dc, we, serial}
  logic [3:0]   q_ack[$];
  // {we, addr, data, serial, wserial}; fields that do not apply are zero
  logic [99:0]  q_mem[$];
  // {is_dc, serial, data}
  logic [66:0]  q_rd[$];
  logic [0:0]   q_wr[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got output with empty scoreboard, expected none", name);
  endtask

  function automatic logic [99:0] mem_pack(input logic we, input logic [31:0] a,
                                           input logic [63:0] d, input logic [1:0] s,
                                           input logic [0:0] ws);
    return we ? {1'b1, a, d, 2'b00, ws} : {1'b0, a, 64'h0, s, 1'b0};
  endfunction

  task automatic exp_ack(input logic dc, input logic we, input logic [1:0] s);
    q_ack.push_back({dc, we, s});
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] a, input logic [63:0] d,
                         input logic [1:0] s, input logic [0:0] ws);
    q_mem.push_back(mem_pack(we, a, d, s, ws));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ic_req_ack && dc_req_ack) unexpected("double_grant");
        if (ic_req_ack || dc_req_ack) begin
          if (q_ack.size() == 0) unexpected("ack");
          else chk("ack", ic_req_ack ? {2'b00, ic_req_serial}
                                      : {1'b1, dc_req_we, dc_req_we ? {1'b0, dc_req_wserial} : dc_req_serial},
                   q_ack.pop_front());
        end
        if (mem_req_valid && mem_req_ready) begin
          if (q_mem.size() == 0) unexpected("mem_req");
          else chk("mem_req", mem_pack(mem_req_we, mem_req_addr, mem_req_data,
                                       mem_req_serial, mem_req_wserial), q_mem.pop_front());
        end
        if (ic_rd_valid || dc_rd_valid) begin
          if (ic_rd_valid && dc_rd_valid) unexpected("double_rd");
          if (q_rd.size() == 0) unexpected("rd_route");
          else chk("rd_route", {dc_rd_valid, rd_serial, rd_data}, q_rd.pop_front());
        end
        if (dc_wr_valid) begin
          if (q_wr.size() == 0) unexpected("wr_route");
          else chk("wr_route", dc_wr_serial, q_wr.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_valid = 0; dc_req_valid = 0; dc_req_we = 0;
    mem_rd_valid = 0; mem_wr_valid = 0; mem_req_ready = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic drained(input string name);
    chk({name, "_q_ack"}, q_ack.size(), 0);
    chk({name, "_q_mem"}, q_mem.size(), 0);
    chk({name, "_q_rd"},  q_rd.size(),  0);
    chk({name, "_q_wr"},  q_wr.size(),  0);
  endtask

  initial begin
    #200000;
    tests++;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  logic [6:0]  rr_ic, rr_dc;
  logic [31:0] w_addr[3];
  logic [63:0] w_data[3];
  logic [1:0]  ret_ser[3];
  logic [63:0] ret_dat[3];
  logic        ret_dc[3];

  initial begin
    // ---------------- reset + basic read
    reset_dut();
    @(negedge clk);
    chk("rst_inflight", rd_inflight, 0);
    chk("rst_err", err, 0);
    chk("rst_memv", mem_req_valid, 0);
    chk("rst_outv", {ic_rd_valid, dc_rd_valid, dc_wr_valid}, 0);
    chk("rst_ack", {ic_req_ack, dc_req_ack}, 0);
    step();
    ic_req_valid = 1; ic_req_addr = 32'h1000; mem_req_ready = 1;
    exp_ack(0, 0, 0);
    exp_mem(0, 32'h1000, 0, 0, 0);
    @(negedge clk);
    chk("b_ack", ic_req_ack, 1);
    chk("b_ser", ic_req_serial, 0);
    step();
    ic_req_valid = 0;
    @(negedge clk);
    chk("b_memv", mem_req_valid, 1);
    chk("b_addr", mem_req_addr, 32'h1000);
    chk("b_infl1", rd_inflight, 1);
    step();
    mem_rd_valid = 1; mem_rd_serial = 0; mem_rd_data = 64'hA5A5;
    q_rd.push_back({1'b0, 2'd0, 64'hA5A5});
    @(negedge clk);
    chk("b_memv_clr", mem_req_valid, 0);
    step();
    mem_rd_valid = 0;
    @(negedge clk);
    chk("b_icrdv", ic_rd_valid, 1);
    chk("b_infl0", rd_inflight, 0);
    step();
    @(negedge clk);
    chk("b_pulse", ic_rd_valid, 0);
    drained("basic");

    // ---------------- round-robin conflict, pool exhaustion, free then reallocate
    reset_dut();
    mem_req_ready = 1;
    ic_req_valid = 1; ic_req_addr = 32'h2000;
    dc_req_valid = 1; dc_req_we = 0; dc_req_addr = 32'h3000;
    exp_ack(0, 0, 0); exp_mem(0, 32'h2000, 0, 0, 0);
    exp_ack(1, 0, 1); exp_mem(0, 32'h3000, 0, 1, 0);
    exp_ack(0, 0, 2); exp_mem(0, 32'h2000, 0, 2, 0);
    exp_ack(1, 0, 0); exp_mem(0, 32'h3000, 0, 0, 0);
    rr_ic = 7'b0000101;
    rr_dc = 7'b1000010;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin
        mem_rd_valid = 1; mem_rd_serial = 0; mem_rd_data = 64'h1111;
        q_rd.push_back({1'b0, 2'd0, 64'h1111});
      end else begin
        mem_rd_valid = 0;
      end
      @(negedge clk);
      chk("rr_ic_ack", ic_req_ack, rr_ic[c]);
      chk("rr_dc_ack", dc_req_ack, rr_dc[c]);
      if (c == 4) chk("rr_full_infl", rd_inflight, 3);
      step();
    end
    ic_req_valid = 0; dc_req_valid = 0;
    ret_ser[0] = 1; ret_dat[0] = 64'h2222; ret_dc[0] = 1;
    ret_ser[1] = 2; ret_dat[1] = 64'h3333; ret_dc[1] = 0;
    ret_ser[2] = 0; ret_dat[2] = 64'h4444; ret_dc[2] = 1;
    for (int k = 0; k < 3; k++) begin
      mem_rd_valid = 1; mem_rd_serial = ret_ser[k]; mem_rd_data = ret_dat[k];
      q_rd.push_back({ret_dc[k], ret_ser[k], ret_dat[k]});
      step();
    end
    mem_rd_valid = 0;
    step(); step();
    @(negedge clk);
    chk("rr_infl0", rd_inflight, 0);
    drained("rr");

    // ---------------- backpressure
    reset_dut();
    ic_req_valid = 1; ic_req_addr = 32'h5000;
    exp_ack(0, 0, 0); exp_mem(0, 32'h5000, 0, 0, 0);
    @(negedge clk);
    chk("bp_ack0", ic_req_ack, 1);
    step();
    ic_req_addr = 32'h5040;
    exp_ack(0, 0, 1); exp_mem(0, 32'h5040, 0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_v", mem_req_valid, 1);
      chk("bp_hold_addr", mem_req_addr, 32'h5000);
      chk("bp_hold_ser", mem_req_serial, 0);
      chk("bp_no_ack", ic_req_ack, 0);
      step();
    end
    mem_req_ready = 1;
    @(negedge clk);
    chk("bp_ack1", ic_req_ack, 1);
    chk("bp_ser1", ic_req_serial, 1);
    step();
    ic_req_valid = 0;
    @(negedge clk);
    chk("bp_addr2", mem_req_addr, 32'h5040);
    step();
    @(negedge clk);
    chk("bp_empty", mem_req_valid, 0);
    drained("bp");

    // ---------------- write path
    reset_dut();
    mem_req_ready = 1;
    w_addr[0] = 32'h6000; w_data[0] = 64'h0123_4567_89AB_CDEF;
    w_addr[1] = 32'h6040; w_data[1] = 64'hFEDC_BA98_7654_3210;
    w_addr[2] = 32'h6080; w_data[2] = 64'h5A5A_0000_FFFF_C3C3;
    exp_ack(1, 1, 0); exp_mem(1, w_addr[0], w_data[0], 0, 0);
    exp_ack(1, 1, 1); exp_mem(1, w_addr[1], w_data[1], 0, 1);
    exp_ack(1, 1, 1); exp_mem(1, w_addr[2], w_data[2], 0, 1);
    dc_req_valid = 1; dc_req_we = 1;
    for (int c = 0; c < 6; c++) begin
      dc_req_addr = w_addr[c > 2 ? 2 : c];
      dc_req_data = w_data[c > 2 ? 2 : c];
      if (c == 4) begin
        mem_wr_valid = 1; mem_wr_serial = 1;
        q_wr.push_back(1'b1);
      end else begin
        mem_wr_valid = 0;
      end
      @(negedge clk);
      chk("wr_ack", dc_req_ack, (c < 2 || c == 5) ? 1'b1 : 1'b0);
      if (c == 1) chk("wr_ws1", dc_req_wserial, 1);
      if (c == 5) begin
        chk("wr_ws_realloc", dc_req_wserial, 1);
        chk("wr_done_v", dc_wr_valid, 1);
      end
      step();
    end
    dc_req_valid = 0;
    mem_wr_valid = 1; mem_wr_serial = 0; q_wr.push_back(1'b0);
    step();
    mem_wr_serial = 1; q_wr.push_back(1'b1);
    step();
    mem_wr_valid = 0;
    step(); step();
    @(negedge clk);
    chk("wr_err_clear", err, 0);
    drained("wr");

    // ---------------- error response and async reset mid-transfer
    reset_dut();
    mem_rd_valid = 1; mem_rd_serial = 2; mem_rd_data = 64'hDEAD;
    step();
    mem_rd_valid = 0;
    @(negedge clk);
    chk("err_set", err, 1);
    chk("err_no_route", {ic_rd_valid, dc_rd_valid}, 0);
    chk("err_infl", rd_inflight, 0);
    step();
    ic_req_valid = 1; ic_req_addr = 32'h7000;
    exp_ack(0, 0, 0);
    @(negedge clk);
    chk("er_ack", ic_req_ack, 1);
    step();
    ic_req_valid = 0;
    @(negedge clk);
    chk("er_memv", mem_req_valid, 1);
    chk("er_infl1", rd_inflight, 1);
    chk("er_err_sticky", err, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_memv", mem_req_valid, 0);
    chk("ar_err", err, 0);
    chk("ar_infl", rd_inflight, 0);
    @(posedge clk);
    #1 rst_n = 1;
    mem_req_ready = 1;
    ic_req_valid = 1; ic_req_addr = 32'h7040;
    exp_ack(0, 0, 0); exp_mem(0, 32'h7040, 0, 0, 0);
    @(negedge clk);
    chk("ar_ack", ic_req_ack, 1);
    chk("ar_ser0", ic_req_serial, 0);
    step();
    ic_req_valid = 0;
    step(); step();
    drained("er");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Shares the single main-memory request port between the I-cache fill path (reads only) and the D-cache memory-port multiplexer (MSHR reads and victim writebacks). It allocates read serials (one pool covering MSHR_NUM+1 outstanding reads) and write serials (MSHR_NUM outstanding writes). It returns each allocated serial in the same-cycle ack, then routes each memory read result or write response back to the requester that owns the serial. It sits between the cache system and the memory interface.

## Interface
- ADDR_W, 32: physical address width (PHY_ADDR_WIDTH).
- LINE_W, 64: line width in bits (DCACHE_LINE_BIT_WIDTH).
- RSER_NUM, 3: read serials (MSHR_NUM+1); RS_W = $clog2(RSER_NUM).
- WSER_NUM, 2: write serials (MSHR_NUM), must be ≥2; WS_W = $clog2(WSER_NUM).

Ports (reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ic_req_valid  in  1  I-cache read request; held until acked
- ic_req_addr  in  ADDR_W  line address
- ic_req_ack  out  1  request accepted this cycle (combinational)
- ic_req_serial  out  RS_W  allocated read serial; valid with ack
- dc_req_valid  in  1  D-cache request; held until acked
- dc_req_we  in  1  1 = write (victim writeback), 0 = read
- dc_req_addr  in  ADDR_W  line address
- dc_req_data  in  LINE_W  write data
- dc_req_ack  out  1  request accepted this cycle (combinational)
- dc_req_serial  out  RS_W  read serial; valid with ack when !we
- dc_req_wserial  out  WS_W  write serial; valid with ack when we
- mem_req_valid, mem_req_we  out  1  registered memory request
- mem_req_addr  out  ADDR_W  address
- mem_req_data  out  LINE_W  write data
- mem_req_serial  out  RS_W  read serial
- mem_req_wserial  out  WS_W  write serial
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_rd_valid  in  1  read result from memory
- mem_rd_serial  in  RS_W  serial of the result
- mem_rd_data  in  LINE_W  line data
- mem_wr_valid  in  1  write completion
- mem_wr_serial  in  WS_W  serial of the completion
- ic_rd_valid, dc_rd_valid  out  1  routed read result (registered)
- rd_serial  out  RS_W  serial of the routed result
- rd_data  out  LINE_W  line data
- dc_wr_valid  out  1  routed write completion (registered)
- dc_wr_serial  out  WS_W  serial of the completion
- rd_inflight  out  $clog2(RSER_NUM+1)  number of allocated read serials
- err  out  1  sticky; set by a response on an unallocated serial

## Operation
- State:
  - rfree[RSER_NUM] and rowner[RSER_NUM] (0 = IC, 1 = DC).
  - wfree[WSER_NUM].
  - lastGrantDC flag.
  - One-entry output slot driving mem_req_*.
- Eligibility:
  - IC is eligible when ic_req_valid and any rfree bit is set.
  - DC is eligible when dc_req_valid and a free serial of the required kind exists.
- Slot availability: slotOK = !mem_req_valid || mem_req_ready.
- Grant:
  - Only when slotOK.
  - If one side is eligible, grant it.
  - If both are eligible, grant the side that was not granted last (round-robin).
  - At most one grant per cycle.
- Allocation: the lowest-index free serial. On grant, clear its free bit, set rowner, load the slot, assert the ack, and update lastGrantDC.
- A read serial is freed on mem_rd_valid. A write serial is freed on mem_wr_valid. A freed serial is allocatable from the next cycle; there is no same-cycle bypass.
- Routing:
  - Next cycle, assert ic_rd_valid or dc_rd_valid according to rowner[mem_rd_serial], with rd_serial and rd_data.
  - dc_wr_valid/dc_wr_serial mirror mem_wr_* one cycle later.
- Error: a response on a serial whose free bit is already set is not routed, leaves the bitmaps unchanged, and sets err.
- rd_inflight = RSER_NUM − popcount(rfree).

## Timing
- Reset values:
  - All free bits = 1.
  - lastGrantDC = 1, so IC wins the first conflict.
  - Every output = 0.
  - rd_inflight = 0.
  - err = 0.
- Reset asserted mid-operation discards all outstanding serials and the slot contents.
- Latency:
  - ack is in cycle T.
  - mem_req_valid is in T+1, held stable until mem_req_ready.
  - A granted request back-to-back with mem_req_ready=1 gives a throughput of 1 request/cycle.
- Response latency: mem_rd_valid in T gives {ic,dc}_rd_valid in T+1. rd_valid/wr_valid are single-cycle pulses.
- Simultaneous free and allocate in the same cycle: allocation sees the pre-free bitmap; the freed serial appears in T+1.
- Full read pool: no read ack from either side. A DC write is still granted if a write serial is free.
- mem_req_ready while the slot is empty is ignored.

## Test plan
- **Basic read:** IC read only, addr=0x1000, mem_req_ready=1.
  - ic_req_ack with serial 0 in cycle 0; mem_req_valid/addr=0x1000/serial=0 in cycle 1.
  - mem_rd_valid serial 0, data=0xA5A5 gives ic_rd_valid, rd_data=0xA5A5 one cycle later; rd_inflight returns to 0.
- **Conflict round-robin:** IC and DC read requests held continuously.
  - Grants alternate IC, DC, IC with serials 0, 1, 2.
  - The fourth request gets no ack until the first mem_rd_valid, then gets the freed serial one cycle after the free.
- **Backpressure:** mem_req_ready=0 for 5 cycles.
  - mem_req_* stay stable; no further acks.
  - After ready=1, the next ack occurs in the same cycle.
- **Write path:**
  - DC issues three writes: acks with wserial 0 and 1; the third is stalled.
  - mem_wr_valid serial 1 gives dc_wr_valid serial 1 a cycle later, and the third write is acked with wserial 1.
- **Error and reset:**
  - mem_rd_valid on unallocated serial 2 sets err, with no rd_valid pulse.
  - rst_n low mid-transfer clears err, empties the slot, and returns rd_inflight to 0.
